armleocpu_plic_gateway: RTL and testbench

//  Interrupt gateway feeding the PLIC core's per-source pending bits. Synchronises raw irq_in lines and converts

---
 rtl/armleocpu_plic_gateway.sv | 165 ++++++++++++++++
 tb/tb_armleocpu_plic_gateway.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_plic_gateway.sv
// Interrupt gateway for the PLIC core.
// Synchronises the raw irq lines and turns level or rising-edge requests into at most
// one outstanding request per source. Each source is held until the core claims and
// then completes it. Edges that arrive while a source is busy are counted in a
// saturating counter; an edge that finds the counter full sets a sticky overflow flag.
module armleocpu_plic_gateway #(
    parameter int INTERRUPT_SOURCE_COUNT = 32,
    parameter int SYNC_STAGES            = 2,
    parameter int EDGE_COUNT_WIDTH       = 4,
    localparam int ID_W = $clog2(INTERRUPT_SOURCE_COUNT) + 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [INTERRUPT_SOURCE_COUNT-1:0] irq_in,
    input  logic [INTERRUPT_SOURCE_COUNT-1:0] irq_edge_mode,
    input  logic                              claim_valid,
    input  logic [ID_W-1:0]                   claim_id,
    input  logic                              complete_valid,
    input  logic [ID_W-1:0]                   complete_id,
    input  logic [INTERRUPT_SOURCE_COUNT-1:0] overflow_clear,
    output logic [INTERRUPT_SOURCE_COUNT-1:0] irq_pending,
    output logic [INTERRUPT_SOURCE_COUNT-1:0] irq_in_service,
    output logic [INTERRUPT_SOURCE_COUNT-1:0] edge_overflow
);

    localparam int N  = INTERRUPT_SOURCE_COUNT;
    localparam int CW = EDGE_COUNT_WIDTH;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PENDING   = 2'd1,
        ST_INSERVICE = 2'd2
    } state_e;

    logic [N-1:0]  sync_r [SYNC_STAGES];
    logic [N-1:0]  prev_r;
    logic [N-1:0]  mode_r;
    logic [N-1:0]  sync_s;
    logic [N-1:0]  rise_s;
    logic [N-1:0]  trig_s;
    logic [N-1:0]  take_s;
    logic [N-1:0]  ovf_set_s;
    state_e        state_r     [N];
    state_e        state_nxt_s [N];
    logic [CW-1:0] cnt_r       [N];
    logic [CW-1:0] cnt_nxt_s   [N];

    // Synchroniser chain plus one-cycle delayed copy of its output for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_r[k] <= '0;
            end
            prev_r <= '0;
        end else begin
            sync_r[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_r[k] <= sync_r[k-1];
            end
            prev_r <= sync_s;
        end
    end

    // Per-source trigger: level follows the synced line, edge uses a fresh rise or a
    // counted backlog; take marks an IDLE source that becomes PENDING this cycle.
    always_comb begin
        sync_s = sync_r[SYNC_STAGES-1];
        rise_s = sync_s & ~prev_r;
        trig_s = '0;
        take_s = '0;
        for (int i = 0; i < N; i++) begin
            if (irq_edge_mode[i]) begin
                trig_s[i] = rise_s[i] | (cnt_r[i] != '0);
            end else begin
                trig_s[i] = sync_s[i];
            end
            take_s[i] = (state_r[i] == ST_IDLE) && trig_s[i];
        end
    end

    // Per-source request state: IDLE -> PENDING -> INSERVICE -> IDLE.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            state_nxt_s[i] = state_r[i];
            case (state_r[i])
                ST_IDLE: begin
                    if (trig_s[i]) begin
                        state_nxt_s[i] = ST_PENDING;
                    end else begin
                        state_nxt_s[i] = ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    if (claim_valid && (claim_id == ID_W'(i + 1))) begin
                        state_nxt_s[i] = ST_INSERVICE;
                    end else begin
                        state_nxt_s[i] = ST_PENDING;
                    end
                end
                ST_INSERVICE: begin
                    if (complete_valid && (complete_id == ID_W'(i + 1))) begin
                        state_nxt_s[i] = ST_IDLE;
                    end else begin
                        state_nxt_s[i] = ST_INSERVICE;
                    end
                end
                default: begin
                    state_nxt_s[i] = ST_IDLE;
                end
            endcase
        end
    end

    // Edge backlog counter: count unconsumed rises, pay one back per backlog-driven
    // request, saturate and flag overflow, and clear on any mode toggle.
    always_comb begin
        ovf_set_s = '0;
        for (int i = 0; i < N; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (irq_edge_mode[i] != mode_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (irq_edge_mode[i]) begin
                if (rise_s[i] && !take_s[i]) begin
                    if (cnt_r[i] == CNT_MAX) begin
                        ovf_set_s[i] = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                    end
                end else if (!rise_s[i] && take_s[i]) begin
                    cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i];
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // State, counters, mode history and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                state_r[i] <= ST_IDLE;
                cnt_r[i]   <= '0;
            end
            mode_r         <= '0;
            irq_pending    <= '0;
            irq_in_service <= '0;
            edge_overflow  <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                state_r[i]        <= state_nxt_s[i];
                cnt_r[i]          <= cnt_nxt_s[i];
                irq_pending[i]    <= (state_nxt_s[i] == ST_PENDING);
                irq_in_service[i] <= (state_nxt_s[i] == ST_INSERVICE);
            end
            mode_r        <= irq_edge_mode;
            edge_overflow <= ovf_set_s | (edge_overflow & ~overflow_clear);
        end
    end

endmodule

// File: tb/tb_armleocpu_plic_gateway.sv
// Bench for armleocpu_plic_gateway: directed scenarios plus a randomized phase,
// every cycle compared against a request-level reference model.
module tb_armleocpu_plic_gateway;

    localparam int N    = 32;
    localparam int SYNC = 2;
    localparam int ID_W = 6;
    localparam int CMAX = 15;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    irq_in;
    logic [N-1:0]    irq_edge_mode;
    logic            claim_valid;
    logic [ID_W-1:0] claim_id;
    logic            complete_valid;
    logic [ID_W-1:0] complete_id;
    logic [N-1:0]    overflow_clear;
    logic [N-1:0]    irq_pending;
    logic [N-1:0]    irq_in_service;
    logic [N-1:0]    edge_overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: request state per source (0 idle, 1 pending, 2 in service),
    // backlog count, overflow flags and a history of sampled irq_in words.
    int           m_st  [N];
    int           m_cnt [N];
    logic [N-1:0] m_ovf;
    logic [N-1:0] m_mode_prev;
    logic [N-1:0] hist [$];

    always #5 clk = ~clk;

    armleocpu_plic_gateway #(
        .INTERRUPT_SOURCE_COUNT(N),
        .SYNC_STAGES(SYNC),
        .EDGE_COUNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .irq_in(irq_in),
        .irq_edge_mode(irq_edge_mode),
        .claim_valid(claim_valid),
        .claim_id(claim_id),
        .complete_valid(complete_valid),
        .complete_id(complete_id),
        .overflow_clear(overflow_clear),
        .irq_pending(irq_pending),
        .irq_in_service(irq_in_service),
        .edge_overflow(edge_overflow)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < N; i++) begin
            m_st[i]  = 0;
            m_cnt[i] = 0;
        end
        m_ovf       = '0;
        m_mode_prev = '0;
    endtask

    // One clock edge of the model, using the inputs present at that edge.
    task automatic model_edge();
        logic [N-1:0] s;
        logic [N-1:0] p;
        bit rise, trig, took, toggled, newovf;
        s = (hist.size() >= SYNC)     ? hist[hist.size()-SYNC]   : '0;
        p = (hist.size() >= SYNC + 1) ? hist[hist.size()-SYNC-1] : '0;
        for (int i = 0; i < N; i++) begin
            rise    = s[i] && !p[i];
            toggled = (irq_edge_mode[i] != m_mode_prev[i]);
            trig    = irq_edge_mode[i] ? (rise || m_cnt[i] > 0) : s[i];
            took    = 1'b0;
            newovf  = 1'b0;
            if (m_st[i] == 0 && trig) begin
                m_st[i] = 1;
                took = 1'b1;
            end else if (m_st[i] == 1 && claim_valid && int'(claim_id) == i + 1) begin
                m_st[i] = 2;
            end else if (m_st[i] == 2 && complete_valid && int'(complete_id) == i + 1) begin
                m_st[i] = 0;
            end
            if (toggled) begin
                m_cnt[i] = 0;
            end else if (irq_edge_mode[i]) begin
                if (took) begin
                    if (!rise) m_cnt[i] = m_cnt[i] - 1;
                end else if (rise) begin
                    if (m_cnt[i] == CMAX) newovf = 1'b1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end
            end
            if (newovf) m_ovf[i] = 1'b1;
            else if (overflow_clear[i]) m_ovf[i] = 1'b0;
        end
        hist.push_back(irq_in);
        if (hist.size() > 8) void'(hist.pop_front());
        m_mode_prev = irq_edge_mode;
    endtask

    task automatic compare_model();
        logic [N-1:0] ep;
        logic [N-1:0] es;
        for (int i = 0; i < N; i++) begin
            ep[i] = (m_st[i] == 1);
            es[i] = (m_st[i] == 2);
        end
        check_eq("pending", irq_pending, ep);
        check_eq("in_service", irq_in_service, es);
        check_eq("overflow", edge_overflow, m_ovf);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_model();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse(input int idx);
        irq_in[idx] = 1'b1;
        idle(2);
        irq_in[idx] = 1'b0;
        idle(2);
    endtask

    task automatic claim(input int id);
        claim_valid = 1'b1;
        claim_id    = ID_W'(id);
        step();
        claim_valid = 1'b0;
        claim_id    = '0;
    endtask

    task automatic complete(input int id);
        complete_valid = 1'b1;
        complete_id    = ID_W'(id);
        step();
        complete_valid = 1'b0;
        complete_id    = '0;
    endtask

    task automatic wait_pending(input int id);
        int n;
        n = 0;
        while (!irq_pending[id-1] && n < 20) begin
            step();
            n++;
        end
        check_eq("wait_pending", irq_pending[id-1], 1'b1);
    endtask

    task automatic random_cycle();
        logic [N-1:0] flip;
        int pend_q[$];
        int svc_q[$];
        int k;
        flip = '0;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 7) == 0) flip[i] = 1'b1;
        end
        irq_in = irq_in ^ flip;
        if ($urandom_range(0, 199) == 0) begin
            k = int'($urandom_range(0, N - 1));
            irq_edge_mode[k] = ~irq_edge_mode[k];
        end
        overflow_clear = '0;
        if ($urandom_range(0, 19) == 0) begin
            k = int'($urandom_range(0, N - 1));
            overflow_clear[k] = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (m_st[i] == 1) pend_q.push_back(i + 1);
            if (m_st[i] == 2) svc_q.push_back(i + 1);
        end
        claim_valid = ($urandom_range(0, 1) == 1);
        if (pend_q.size() > 0 && $urandom_range(0, 3) != 0)
            claim_id = ID_W'(pend_q[$urandom_range(0, pend_q.size() - 1)]);
        else
            claim_id = ID_W'($urandom_range(0, 63));
        complete_valid = ($urandom_range(0, 3) == 0);
        if (svc_q.size() > 0 && $urandom_range(0, 3) != 0)
            complete_id = ID_W'(svc_q[$urandom_range(0, svc_q.size() - 1)]);
        else
            complete_id = ID_W'($urandom_range(0, 63));
        step();
    endtask

    initial begin
        rst_n          = 1'b0;
        irq_in         = '0;
        irq_edge_mode  = '0;
        irq_edge_mode[0] = 1'b1;
        irq_edge_mode[4] = 1'b1;
        claim_valid    = 1'b0;
        claim_id       = '0;
        complete_valid = 1'b0;
        complete_id    = '0;
        overflow_clear = '0;
        model_reset();
        idle(2);
        rst_n = 1'b1;

        // Level source 3: latency, claim, re-assert two edges after complete.
        irq_in[2] = 1'b1;
        idle(2);
        check_eq("lvl_lat_early", irq_pending[2], 1'b0);
        step();
        check_eq("lvl_lat", irq_pending[2], 1'b1);
        claim(3);
        check_eq("lvl_claim_pend", irq_pending[2], 1'b0);
        check_eq("lvl_claim_svc", irq_in_service[2], 1'b1);
        complete(3);
        check_eq("lvl_cpl_idle", irq_pending[2], 1'b0);
        step();
        check_eq("lvl_repend", irq_pending[2], 1'b1);
        irq_in[2] = 1'b0;
        claim(3);
        idle(3);
        complete(3);
        idle(2);
        check_eq("lvl_done", irq_pending[2], 1'b0);

        // Edge burst on source 5: three edges while in service need three more rounds.
        pulse(4);
        wait_pending(5);
        claim(5);
        for (int r = 0; r < 3; r++) pulse(4);
        complete(5);
        for (int r = 0; r < 3; r++) begin
            wait_pending(5);
            claim(5);
            complete(5);
        end
        idle(3);
        check_eq("burst_drained", irq_pending[4], 1'b0);

        // Saturation on source 1, overflow clear, then a mode toggle wipes the backlog.
        pulse(0);
        wait_pending(1);
        claim(1);
        for (int r = 0; r < 17; r++) pulse(0);
        check_eq("sat_ovf", edge_overflow[0], 1'b1);
        overflow_clear[0] = 1'b1;
        step();
        overflow_clear[0] = 1'b0;
        check_eq("sat_ovf_clr", edge_overflow[0], 1'b0);
        complete(1);
        wait_pending(1);
        irq_edge_mode[0] = 1'b0;
        step();
        irq_edge_mode[0] = 1'b1;
        step();
        check_eq("toggle_sticky", irq_pending[0], 1'b1);
        claim(1);
        complete(1);
        idle(3);
        check_eq("toggle_cleared", irq_pending[0], 1'b0);

        // Ignored operations on source 7 and out-of-range IDs.
        claim(7);
        check_eq("ign_claim_idle", irq_in_service[6], 1'b0);
        irq_in[6] = 1'b1;
        wait_pending(7);
        complete(7);
        claim(0);
        claim(33);
        check_eq("ign_pend_kept", irq_pending[6], 1'b1);
        claim(7);
        check_eq("ign_claim_ok", irq_in_service[6], 1'b1);
        irq_in[6] = 1'b0;
        idle(3);
        complete(7);

        // Same-cycle claim of 2 and complete of 4.
        irq_in[1] = 1'b1;
        irq_in[3] = 1'b1;
        wait_pending(2);
        wait_pending(4);
        claim(4);
        irq_in[3] = 1'b0;
        idle(3);
        claim_valid    = 1'b1;
        claim_id       = 6'd2;
        complete_valid = 1'b1;
        complete_id    = 6'd4;
        step();
        claim_valid    = 1'b0;
        complete_valid = 1'b0;
        check_eq("same_svc2", irq_in_service[1], 1'b1);
        check_eq("same_idle4", {irq_pending[3], irq_in_service[3]}, 2'b00);
        irq_in[1] = 1'b0;
        idle(3);
        complete(2);

        // Mid-cycle reset with pending, in-service and counted requests.
        irq_in[8] = 1'b1;
        irq_in[9] = 1'b1;
        wait_pending(10);
        claim(9);
        pulse(4);
        wait_pending(5);
        claim(5);
        pulse(4);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("rst_pend", irq_pending, '0);
        check_eq("rst_svc", irq_in_service, '0);
        check_eq("rst_ovf", edge_overflow, '0);
        irq_in = '0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check_eq("rst_no_replay", irq_pending, '0);

        // Randomized phase against the model.
        for (int c = 0; c < 3000; c++) random_cycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
